hdmi_video_timing: RTL

Video timing generator for the HDMI output path. Runs on the pixel clock from the HDMI PLL and produces registered hsync/vsync/data-enable with pixel coordinates for the downstream TMDS encoder. It also issues a pixel-request strobe a fixed number of cycles ahead of data-enable, so the upstream frame buffer or ISP stage can have each pixel ready exactly when it is displayed. Defaults are CEA-861 1280x720p60 at 74.25 MHz; the same block serves 1920x1080p30 through parameters.

---
 rtl/hdmi_video_timing.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hdmi_video_timing.sv
// Video timing generator: raster counters, sync/enable decode and a lead-ahead pixel request.
// Defaults give CEA-861 1280x720p60; every output is registered one cycle after the counters.
module hdmi_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int LEAD     = 2
) (
  input  logic        clk_pix,
  input  logic        srst,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        sof,
  output logic        eol,
  output logic        req,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] H_EOL    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] LEAD_W   = 12'(LEAD);

  generate
    if (H_TOTAL > 4095 || V_TOTAL > 4095 || LEAD < 1 || LEAD > H_TOTAL - 1) begin : g_bad_cfg
      $error("hdmi_video_timing: raster totals must be <= 4095 and LEAD within 1..H_TOTAL-1");
    end
  endgenerate

  function automatic logic [11:0] h_step(input logic [11:0] h);
    return (h == H_LAST) ? 12'd0 : h + 12'd1;
  endfunction

  function automatic logic [11:0] v_step(input logic [11:0] h, input logic [11:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? 12'd0 : v + 12'd1;
  endfunction

  function automatic logic is_active(input logic [11:0] h, input logic [11:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  function automatic logic hs_act(input logic [11:0] h);
    return (h >= HS_START) && (h < HS_END);
  endfunction

  function automatic logic vs_act(input logic [11:0] v);
    return (v >= VS_START) && (v < VS_END);
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic        vld_p0;
  logic [11:0] h_p0, v_p0, rh_p0, rv_p0;

  always_ff @(posedge clk_pix) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Counters only advance once RUN is established, so the edge that first sees en
  // high still holds the origin; this fixes the start-up delay to one extra cycle.
  always_comb begin
    state_nxt = state;
    vld_p0    = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (en) vld_p0 = 1'b1;
        else    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: display counters and the request counters running LEAD positions ahead
  always_ff @(posedge clk_pix) begin
    if (srst || !vld_p0) begin
      h_p0  <= 12'd0;
      v_p0  <= V_ACT;
      rh_p0 <= LEAD_W;
      rv_p0 <= V_ACT;
    end else begin
      h_p0  <= h_step(h_p0);
      v_p0  <= v_step(h_p0, v_p0);
      rh_p0 <= h_step(rh_p0);
      rv_p0 <= v_step(rh_p0, rv_p0);
    end
  end

  // Stage p1: registered outputs decoded from the p0 counters
  always_ff @(posedge clk_pix) begin
    if (srst || !vld_p0) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      x     <= 12'd0;
      y     <= 12'd0;
      sof   <= 1'b0;
      eol   <= 1'b0;
      req   <= 1'b0;
      req_x <= 12'd0;
      req_y <= 12'd0;
    end else begin
      hsync <= hs_act(h_p0) ? HS_POL : ~HS_POL;
      vsync <= vs_act(v_p0) ? VS_POL : ~VS_POL;
      de    <= is_active(h_p0, v_p0);
      x     <= h_p0;
      y     <= v_p0;
      sof   <= (h_p0 == 12'd0) && (v_p0 == 12'd0);
      eol   <= (h_p0 == H_EOL) && (v_p0 < V_ACT);
      req   <= is_active(rh_p0, rv_p0);
      req_x <= rh_p0;
      req_y <= rv_p0;
    end
  end

  // frame_cnt survives an en drop; only srst clears it
  always_ff @(posedge clk_pix) begin
    if (srst) begin
      frame_cnt <= 16'd0;
    end else if (vld_p0 && (h_p0 == 12'd0) && (v_p0 == 12'd0)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
